// File: rtl/aes_round_seq_pkg.sv
// Shared types and constants for the AES round sequencer:
// key-mode encoding, round counts and the mode-to-round-count mapping.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'd0,
        AES192 = 2'd1,
        AES256 = 2'd2
    } key_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;
    localparam logic [3:0] NR_MAX = 4'd14;
    localparam int         RND_W  = 4;
    localparam int         CR_W   = 15;

    // The reserved encoding falls back to the AES-128 round count
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        logic [3:0] nr;
        case (mode)
            AES128:  nr = NR_128;
            AES192:  nr = NR_192;
            AES256:  nr = NR_256;
            default: nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_seq_if.sv
// Start handshake, control inputs and stage-enable outputs of the round sequencer.
// The master drives the requests; the sequencer sits on the slave side.
interface aes_round_seq_if #(parameter int N = 4) ();
    import aes_ctrl_pkg::*;

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic              start_valid;
    logic              start_ready;
    logic [1:0]        key_mode;
    logic              hold;
    logic              abort;
    logic [CNT_W-1:0]  slot;
    logic [RND_W-1:0]  rnd_no;
    logic [RND_W-1:0]  nr;
    logic              enb_sb;
    logic              enb_sr;
    logic              enb_mc;
    logic              enb_ar;
    logic              enb_ks;
    logic              busy;
    logic              done;
    logic [CR_W-1:0]   completed_round;
    logic              mode_err;

    modport master (
        output start_valid, key_mode, hold, abort,
        input  start_ready, slot, rnd_no, nr, enb_sb, enb_sr, enb_mc, enb_ar,
               enb_ks, busy, done, completed_round, mode_err
    );

    modport slave (
        input  start_valid, key_mode, hold, abort,
        output start_ready, slot, rnd_no, nr, enb_sb, enb_sr, enb_mc, enb_ar,
               enb_ks, busy, done, completed_round, mode_err
    );

endinterface

// File: rtl/aes_round_seq_slot_counter.sv
// Modulo-N channel slot counter with enable and synchronous clear.
// wrap flags the last slot so the round counter can advance on it.
module aes_slot_counter #(
    parameter int N     = 4,
    parameter int CNT_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] slot,
    output logic             wrap
);

    logic [CNT_W-1:0] slot_q;
    logic [CNT_W-1:0] slot_d;

    assign wrap = (slot_q == CNT_W'(N - 1));
    assign slot = slot_q;

    // Clear wins over enable so an abort or new accept always restarts at slot 0
    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = '0;
        end else if (en) begin
            slot_d = wrap ? '0 : slot_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/aes_round_seq.sv
// Round sequencer: interleaves N channel slots through 10/12/14 AES rounds
// and drives the datapath stage enables from registered state.
module aes_round_seq
    import aes_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    aes_round_seq_if.slave  bus
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    seq_state_e       state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [RND_W-1:0] nr_q, nr_d;
    logic [CNT_W-1:0] slot;
    logic             wrap;
    logic             last_beat;
    logic             start_ready;
    logic             accept;
    logic             cnt_en;
    logic             cnt_clr;
    logic             run_d;

    logic             enb_sb_q, enb_sb_d;
    logic             enb_sr_q, enb_sr_d;
    logic             enb_mc_q, enb_mc_d;
    logic             enb_ar_q, enb_ar_d;
    logic             enb_ks_q, enb_ks_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CR_W-1:0]  cr_q, cr_d;

    assign last_beat   = (state_q == ST_RUN) && (rnd_q == nr_q) && wrap;
    assign start_ready = !bus.abort && !bus.hold && ((state_q == ST_IDLE) || last_beat);
    assign accept      = bus.start_valid && start_ready;
    assign cnt_en      = (state_q == ST_RUN) && !bus.hold;
    assign cnt_clr     = bus.abort || accept;

    aes_slot_counter #(.N(N), .CNT_W(CNT_W)) u_slot_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .slot (slot),
        .wrap (wrap)
    );

    // Next state: abort beats hold, and accept is impossible while either is high
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        nr_d    = nr_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
            rnd_d   = '0;
        end else if (accept) begin
            state_d = ST_RUN;
            rnd_d   = '0;
            nr_d    = nr_of(bus.key_mode);
        end else if (!bus.hold && (state_q == ST_RUN) && wrap) begin
            if (rnd_q == nr_q) begin
                state_d = ST_IDLE;
                rnd_d   = '0;
            end else begin
                rnd_d = rnd_q + 4'd1;
            end
        end
    end

    // Outputs are decoded from next state so they leave the flops aligned with it
    always_comb begin
        run_d    = (state_d == ST_RUN);
        enb_ar_d = run_d;
        enb_ks_d = run_d;
        enb_sb_d = run_d && (rnd_d != '0);
        enb_sr_d = run_d && (rnd_d != '0);
        enb_mc_d = run_d && (rnd_d != '0) && (rnd_d != nr_d);
        busy_d   = run_d;
        done_d   = run_d && (rnd_d == nr_d);
        cr_d     = run_d ? (15'd1 << rnd_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rnd_q    <= '0;
            nr_q     <= NR_128;
            enb_sb_q <= 1'b0;
            enb_sr_q <= 1'b0;
            enb_mc_q <= 1'b0;
            enb_ar_q <= 1'b0;
            enb_ks_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cr_q     <= '0;
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            nr_q     <= nr_d;
            enb_sb_q <= enb_sb_d;
            enb_sr_q <= enb_sr_d;
            enb_mc_q <= enb_mc_d;
            enb_ar_q <= enb_ar_d;
            enb_ks_q <= enb_ks_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cr_q     <= cr_d;
        end
    end

    assign bus.start_ready     = start_ready;
    assign bus.mode_err        = accept && (bus.key_mode == 2'd3);
    assign bus.slot            = slot;
    assign bus.rnd_no          = rnd_q;
    assign bus.nr              = nr_q;
    assign bus.enb_sb          = enb_sb_q;
    assign bus.enb_sr          = enb_sr_q;
    assign bus.enb_mc          = enb_mc_q;
    assign bus.enb_ar          = enb_ar_q;
    assign bus.enb_ks          = enb_ks_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.completed_round = cr_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: a vector table for one AES-128 block on N=4,
// then hand-written sequences for back-to-back, hold, abort, reset, mode 3 and N=1.
module tb_aes_round_seq;

    typedef struct {
        int          cyc;
        logic [3:0]  rnd;
        logic [1:0]  slot;
        logic        busy;
        logic        done;
        logic        sb;
        logic        mc;
        logic        ready;
        logic [14:0] cr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks_total  = 0;
    int   checks_passed = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    aes_round_seq_if #(.N(4)) bus4 ();
    aes_round_seq_if #(.N(1)) bus1 ();

    aes_round_seq #(.N(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    aes_round_seq #(.N(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic sv, input logic [1:0] km, input logic h, input logic a);
        bus4.start_valid = sv;
        bus4.key_mode    = km;
        bus4.hold        = h;
        bus4.abort       = a;
        #1;
    endtask

    function automatic logic [4:0] enables4();
        return {bus4.enb_sb, bus4.enb_sr, bus4.enb_mc, bus4.enb_ar, bus4.enb_ks};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gaps;
        int done_seen;
        int slot_nonzero;

        vecs[0] = '{1,  4'd0,  2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0001};
        vecs[1] = '{4,  4'd0,  2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0001};
        vecs[2] = '{5,  4'd1,  2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0002};
        vecs[3] = '{40, 4'd9,  2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0200};
        vecs[4] = '{41, 4'd10, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0400};
        vecs[5] = '{44, 4'd10, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 15'h0400};
        vecs[6] = '{45, 4'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0000};
        vecs[7] = '{46, 4'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0000};

        rst = 1'b1;
        bus1.start_valid = 1'b0;
        bus1.key_mode    = 2'd0;
        bus1.hold        = 1'b0;
        bus1.abort       = 1'b0;
        apply_stimulus(0, 0, 0, 0);
        tick();
        tick();
        check_output("reset busy", bus4.busy, 0);
        check_output("reset done", bus4.done, 0);
        check_output("reset nr", bus4.nr, 10);
        check_output("reset rnd", bus4.rnd_no, 0);
        check_output("reset slot", bus4.slot, 0);
        check_output("reset enables", enables4(), 0);
        check_output("reset cr", bus4.completed_round, 0);
        check_output("reset ready", bus4.start_ready, 1);
        check_output("reset mode_err", bus4.mode_err, 0);
        rst = 1'b0;
        tick();

        // AES-128 single block, checked against the vector table
        apply_stimulus(1, 0, 0, 0);
        check_output("t1 accept ready", bus4.start_ready, 1);
        check_output("t1 accept mode_err", bus4.mode_err, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        for (int c = 1; c <= 46; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (vecs[i].cyc == c) begin
                    check_output($sformatf("t1 c%0d rnd", c), bus4.rnd_no, vecs[i].rnd);
                    check_output($sformatf("t1 c%0d slot", c), bus4.slot, vecs[i].slot);
                    check_output($sformatf("t1 c%0d busy", c), bus4.busy, vecs[i].busy);
                    check_output($sformatf("t1 c%0d done", c), bus4.done, vecs[i].done);
                    check_output($sformatf("t1 c%0d sb", c), bus4.enb_sb, vecs[i].sb);
                    check_output($sformatf("t1 c%0d mc", c), bus4.enb_mc, vecs[i].mc);
                    check_output($sformatf("t1 c%0d ready", c), bus4.start_ready, vecs[i].ready);
                    check_output($sformatf("t1 c%0d cr", c), bus4.completed_round, vecs[i].cr);
                end
            end
            tick();
        end

        // AES-256 back-to-back with start_valid held high
        apply_stimulus(1, 2, 0, 0);
        tick();
        gaps = 0;
        for (int c = 1; c <= 121; c++) begin
            if (c == 62) apply_stimulus(0, 0, 0, 0);
            if (c <= 120 && !bus4.busy) gaps++;
            if (c == 1)   check_output("t2 nr", bus4.nr, 14);
            if (c == 60) begin
                check_output("t2 c60 rnd", bus4.rnd_no, 14);
                check_output("t2 c60 slot", bus4.slot, 3);
                check_output("t2 c60 done", bus4.done, 1);
                check_output("t2 c60 ready", bus4.start_ready, 1);
            end
            if (c == 61) begin
                check_output("t2 c61 rnd", bus4.rnd_no, 0);
                check_output("t2 c61 slot", bus4.slot, 0);
                check_output("t2 c61 done", bus4.done, 0);
                check_output("t2 c61 busy", bus4.busy, 1);
            end
            if (c == 100) check_output("t2 nr ignores key_mode", bus4.nr, 14);
            if (c == 120) check_output("t2 c120 done", bus4.done, 1);
            if (c == 121) check_output("t2 c121 busy", bus4.busy, 0);
            tick();
        end
        check_output("t2 gap cycles", gaps, 0);

        // Three hold cycles at round 5 slot 2 shift the done window by three
        apply_stimulus(1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        for (int c = 1; c <= 48; c++) begin
            if (c == 23) begin
                apply_stimulus(0, 0, 1, 0);
                check_output("t3 hold ready", bus4.start_ready, 0);
            end
            if (c == 26) apply_stimulus(0, 0, 0, 0);
            if (c >= 23 && c <= 26) begin
                check_output($sformatf("t3 c%0d rnd", c), bus4.rnd_no, 5);
                check_output($sformatf("t3 c%0d slot", c), bus4.slot, 2);
            end
            if (c == 27) check_output("t3 c27 slot", bus4.slot, 3);
            if (c == 43) check_output("t3 c43 done", bus4.done, 0);
            if (c == 44) check_output("t3 c44 done", bus4.done, 1);
            if (c == 47) check_output("t3 c47 done", bus4.done, 1);
            if (c == 48) check_output("t3 c48 busy", bus4.busy, 0);
            tick();
        end

        // Abort at round 7
        apply_stimulus(1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        done_seen = 0;
        for (int c = 1; c <= 32; c++) begin
            if (bus4.done) done_seen++;
            if (c == 29) check_output("t4 c29 rnd", bus4.rnd_no, 7);
            if (c == 30) begin
                apply_stimulus(0, 0, 0, 1);
                check_output("t4 abort ready", bus4.start_ready, 0);
            end
            if (c == 31) begin
                apply_stimulus(0, 0, 0, 0);
                check_output("t4 busy", bus4.busy, 0);
                check_output("t4 enables", enables4(), 0);
                check_output("t4 rnd", bus4.rnd_no, 0);
                check_output("t4 slot", bus4.slot, 0);
                check_output("t4 ready", bus4.start_ready, 1);
            end
            tick();
        end
        check_output("t4 done never", done_seen, 0);

        // Synchronous reset in the middle of an AES-256 block
        apply_stimulus(1, 2, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        for (int c = 1; c <= 9; c++) tick();
        check_output("t4r running nr", bus4.nr, 14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("t4r busy", bus4.busy, 0);
        check_output("t4r nr", bus4.nr, 10);
        check_output("t4r rnd", bus4.rnd_no, 0);
        check_output("t4r slot", bus4.slot, 0);
        check_output("t4r enables", enables4(), 0);
        check_output("t4r done", bus4.done, 0);
        check_output("t4r ready", bus4.start_ready, 1);
        tick();

        // Reserved key mode
        apply_stimulus(1, 3, 0, 0);
        check_output("t5 mode_err", bus4.mode_err, 1);
        tick();
        apply_stimulus(0, 3, 0, 0);
        check_output("t5 mode_err after", bus4.mode_err, 0);
        check_output("t5 nr", bus4.nr, 10);
        for (int c = 1; c <= 45; c++) begin
            if (c == 44) begin
                check_output("t5 c44 busy", bus4.busy, 1);
                check_output("t5 c44 done", bus4.done, 1);
            end
            if (c == 45) check_output("t5 c45 busy", bus4.busy, 0);
            tick();
        end

        // Single-slot instance running AES-192
        bus1.start_valid = 1'b1;
        bus1.key_mode    = 2'd1;
        #1;
        check_output("t6 ready", bus1.start_ready, 1);
        tick();
        bus1.start_valid = 1'b0;
        slot_nonzero = 0;
        for (int c = 1; c <= 14; c++) begin
            if (bus1.slot != 0) slot_nonzero++;
            if (c == 1)  check_output("t6 c1 rnd", bus1.rnd_no, 0);
            if (c == 2)  check_output("t6 c2 rnd", bus1.rnd_no, 1);
            if (c == 12) check_output("t6 c12 done", bus1.done, 0);
            if (c == 13) begin
                check_output("t6 c13 rnd", bus1.rnd_no, 12);
                check_output("t6 c13 done", bus1.done, 1);
                check_output("t6 nr", bus1.nr, 12);
            end
            if (c == 14) check_output("t6 c14 busy", bus1.busy, 0);
            tick();
        end
        check_output("t6 slot stays 0", slot_nonzero, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/aes_round_seq.md
# aes_round_seq

Parametrised round sequencer for the N-channel AES encoder. Time-multiplexes N channel slots through the round pipeline and supports AES-128/192/256 (10/12/14 rounds) selected per block. Adds a valid/ready start handshake, back-to-back block issue, stall (hold) and abort. Drives the round-stage enables of the datapath and the key-schedule unit.

## Interface
Parameters:
- N, 4, number of interleaved channel slots (≥1)
- CNT_W, max(1,$clog2(N)), slot counter width (derived; not overridden)

Ports:
- clk, in, 1, clock
- rst, in, 1, reset, synchronous, active-high
- start_valid, in, 1, request to begin a new block
- start_ready, out, 1, sequencer can accept a block this cycle
- key_mode, in, 2, 0=AES-128, 1=AES-192, 2=AES-256, 3=reserved; sampled at accept
- hold, in, 1, freeze all state (downstream stall)
- abort, in, 1, terminate the current block
- slot, out, CNT_W, current channel slot
- rnd_no, out, 4, current round 0..nr
- nr, out, 4, latched final round number (10/12/14)
- enb_sb, enb_sr, enb_mc, enb_ar, enb_ks, out, 1 each, stage enables
- busy, out, 1, state is RUN
- done, out, 1, final round in progress (one cycle per slot)
- completed_round, out, 15, one-hot of rnd_no while RUN; 0 in IDLE
- mode_err, out, 1, one-cycle pulse when key_mode=3 is accepted

## Operation
- FSM states: IDLE, RUN.
- Accept = start_valid && start_ready. On accept:
  - latch nr from key_mode: 0→10, 1→12, 2→14, 3→10 with mode_err pulse;
  - slot=0, rnd_no=0, enter RUN.
- RUN, per non-held cycle:
  - slot increments.
  - At slot==N-1: slot→0 and rnd_no increments.
  - At last beat (rnd_no==nr && slot==N-1): accept → restart at rnd_no=0 with new nr, staying in RUN; otherwise → IDLE.
- start_ready = IDLE || (RUN && last beat && !hold && !abort).
- Enables, RUN only:
  - enb_ar, enb_ks: rnd_no 0..nr
  - enb_sb, enb_sr: 1..nr
  - enb_mc: 1..nr-1
  - In IDLE all enables are 0.
- done = RUN && rnd_no==nr.
- Priority: rst > abort > hold > normal advance.
  - abort: IDLE next cycle with slot=0, rnd_no=0, no done. start_ready is 0 in the abort cycle.
  - hold: slot, rnd_no, nr and state all frozen. Outputs stay at their current values. start_ready=0.
- Reset values: state IDLE; slot 0, rnd_no 0, nr 10; all enables 0, busy 0, done 0, mode_err 0, completed_round 0; start_ready 1.

## Timing
- All outputs decode from registers. The only combinational input-to-output paths are start_ready (from hold, abort) and mode_err (from key_mode, start_valid).
- Accept at edge k → rnd_no=0, slot=0 visible in cycle k+1.
- Block length without hold is N*(nr+1) cycles: 44/52/60 for N=4.
- Back-to-back issue leaves zero idle cycles between blocks.
- Each hold cycle delays completion by exactly one cycle.
- key_mode changes during RUN have no effect until the next accept.

## Structure
- Package aes_ctrl_pkg holds:
  - key-mode enum (AES128/AES192/AES256);
  - constants NR_128=10, NR_192=12, NR_256=14, NR_MAX=14;
  - function nr_of(mode).
- Sub-module aes_slot_counter: modulo-N counter with enable and sync clear; outputs slot and a wrap flag. The FSM and round counter stay in aes_round_seq.

## Test plan
- N=4, key_mode=0, single accept at cycle 0 → rnd_no 0 in cycles 1–4, enb_mc=0 in round 10, done high cycles 41–44, busy=0 and start_ready=1 from cycle 45.
- N=4, key_mode=2, start_valid held high → nr=14; second block rnd_no=0 in the cycle after round-14 slot 3; each block 60 cycles, no gap.
- hold asserted for 3 cycles at round 5 slot 2 → slot/rnd_no frozen, start_ready=0; done window shifts 3 cycles later.
- abort at round 7 → busy=0, all enables 0 next cycle, done never asserted; rst mid-RUN gives the same result with nr=10.
- key_mode=3 at accept → mode_err high for exactly the accept cycle, nr=10, block runs 44 cycles.
- N=1 → slot stays 0, rnd_no advances every cycle; AES-192 block completes in 13 cycles.
